// File: rtl/expand_accumulate_if.sv
// expand_accumulate_if: sample stream in, block sum out.
// master drives samples/clear, slave produces sums.
interface expand_accumulate_if #(
    parameter int IWIDTH     = 8,
    parameter int LOG2_COUNT = 4
);
    localparam int OWIDTH = IWIDTH + LOG2_COUNT;

    logic                  clear;
    logic                  inValid;
    logic [IWIDTH-1:0]     I;
    logic                  outValid;
    logic [OWIDTH-1:0]     O;
    logic [LOG2_COUNT:0]   clipCount;

    modport master (
        output clear,
        output inValid,
        output I,
        input  outValid,
        input  O,
        input  clipCount
    );

    modport slave (
        input  clear,
        input  inValid,
        input  I,
        output outValid,
        output O,
        output clipCount
    );
endinterface

// File: rtl/expand_accumulate.sv
// expand_accumulate: sums blocks of 2^LOG2_COUNT signed samples at full width.
// Optional rail-sample counting when CLIP_COUNT_EN is defined.
module expand_accumulate #(
    parameter int IWIDTH     = 8,
    parameter int LOG2_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    expand_accumulate_if.slave bus
);
    localparam int OWIDTH = IWIDTH + LOG2_COUNT;
    localparam logic [LOG2_COUNT-1:0] CNT_ONE = LOG2_COUNT'(1);

    logic [OWIDTH-1:0]     acc;
    logic [LOG2_COUNT-1:0] cnt;
    logic [OWIDTH-1:0]     ext;
    logic [OWIDTH-1:0]     sum;
    logic                  take;
    logic                  last;

    // sign-extend the sample and form the running sum including it
    always_comb begin
        take = bus.inValid & ~bus.clear;
        last = take & (&cnt);
        ext  = {{LOG2_COUNT{bus.I[IWIDTH-1]}}, bus.I};
        sum  = acc + ext;
    end

    // accumulate, count samples and publish the block sum on wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            cnt          <= '0;
            bus.O        <= '0;
            bus.outValid <= 1'b0;
        end else begin
            bus.outValid <= 1'b0;
            if (bus.clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (take) begin
                cnt <= cnt + CNT_ONE;
                if (last) begin
                    acc          <= '0;
                    bus.O        <= sum;
                    bus.outValid <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

`ifdef CLIP_COUNT_EN
    localparam logic [IWIDTH-1:0] POS_RAIL = {1'b0, {(IWIDTH-1){1'b1}}};
    localparam logic [IWIDTH-1:0] NEG_RAIL = {1'b1, {(IWIDTH-1){1'b0}}};

    logic [LOG2_COUNT:0] clipAcc;
    logic [LOG2_COUNT:0] clipSum;
    logic                rail;

    // flag samples pinned at either saturation rail
    always_comb begin
        rail    = (bus.I == POS_RAIL) | (bus.I == NEG_RAIL);
        clipSum = clipAcc + {{LOG2_COUNT{1'b0}}, rail};
    end

    // count rail samples per block, published alongside O
    always_ff @(posedge clk) begin
        if (reset) begin
            clipAcc       <= '0;
            bus.clipCount <= '0;
        end else if (bus.clear) begin
            clipAcc <= '0;
        end else if (take) begin
            if (last) begin
                clipAcc       <= '0;
                bus.clipCount <= clipSum;
            end else begin
                clipAcc <= clipSum;
            end
        end
    end
`else
    assign bus.clipCount = '0;
`endif

endmodule
